// File: rtl/mult_if.sv
// Issue / writeback bundle between the EX stage and the multiply manager.
`ifndef MULT_PPL_STAGE
`define MULT_PPL_STAGE 3
`endif

interface mult_if #(
  parameter int STAGES = `MULT_PPL_STAGE,
  parameter int XLEN   = 32
);
  logic                   issue_valid_i;
  logic                   issue_ready_o;
  logic [2:0]             issue_funct3_i;
  logic [XLEN-1:0]        issue_rs1_i;
  logic [XLEN-1:0]        issue_rs2_i;
  logic [4:0]             issue_rd_i;
  logic [STAGES-1:0][4:0] rd_addrs_o;
  logic [STAGES-1:0]      uses_o;
  logic                   wb_we_o;
  logic [4:0]             wb_addr_o;
  logic [XLEN-1:0]        wb_data_o;
  logic                   wb_ready_i;

  modport slave (
    input  issue_valid_i,
    input  issue_funct3_i,
    input  issue_rs1_i,
    input  issue_rs2_i,
    input  issue_rd_i,
    input  wb_ready_i,
    output issue_ready_o,
    output rd_addrs_o,
    output uses_o,
    output wb_we_o,
    output wb_addr_o,
    output wb_data_o
  );

  modport master (
    output issue_valid_i,
    output issue_funct3_i,
    output issue_rs1_i,
    output issue_rs2_i,
    output issue_rd_i,
    output wb_ready_i,
    input  issue_ready_o,
    input  rd_addrs_o,
    input  uses_o,
    input  wb_we_o,
    input  wb_addr_o,
    input  wb_data_o
  );
endinterface

// File: rtl/mult_manager.sv
// Pipelined RV32M multiply unit: in-order issue, stall-on-writeback.
`ifndef MULT_PPL_STAGE
`define MULT_PPL_STAGE 3
`endif

module mult_manager #(
  parameter int STAGES = `MULT_PPL_STAGE,
  parameter int XLEN   = 32
) (
  input  logic  clk,
  input  logic  rst,
  mult_if.slave bus
);
  localparam int PW = 2 * XLEN;

  logic [STAGES-1:0]         vld_q, vld_d;
  logic [STAGES-1:0][4:0]    rd_q, rd_d;
  logic [STAGES-1:0][2:0]    f3_q, f3_d;
  logic [STAGES-1:0][PW-1:0] prod_q, prod_d;

  logic          advance;
  logic          accept;
  logic          sx_a, sx_b;
  logic [PW-1:0] op_a, op_b, prod_in;
  logic [2:0]    f3_last;
  logic          lo_sel;

  assign advance = !(vld_q[STAGES-1] && !bus.wb_ready_i);
  assign accept  = bus.issue_valid_i && advance
                && (bus.issue_rd_i != 5'd0);

  // Operands widened to 2*XLEN; the modular product equals
  // the (XLEN+1)-bit signed product in the bits we keep.
  always_comb begin
    sx_a = (bus.issue_funct3_i == 3'b001)
        || (bus.issue_funct3_i == 3'b010);
    sx_b = (bus.issue_funct3_i == 3'b001);
    op_a = {{XLEN{sx_a & bus.issue_rs1_i[XLEN-1]}},
            bus.issue_rs1_i};
    op_b = {{XLEN{sx_b & bus.issue_rs2_i[XLEN-1]}},
            bus.issue_rs2_i};
    prod_in = op_a * op_b;
  end

  always_comb begin
    vld_d  = vld_q;
    rd_d   = rd_q;
    f3_d   = f3_q;
    prod_d = prod_q;
    if (advance) begin
      for (int k = STAGES - 1; k > 0; k--) begin
        vld_d[k]  = vld_q[k-1];
        rd_d[k]   = rd_q[k-1];
        f3_d[k]   = f3_q[k-1];
        prod_d[k] = prod_q[k-1];
      end
      vld_d[0]  = accept;
      rd_d[0]   = accept ? bus.issue_rd_i : 5'd0;
      f3_d[0]   = accept ? bus.issue_funct3_i : 3'd0;
      prod_d[0] = accept ? prod_in : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      rd_q   <= '0;
      f3_q   <= '0;
      prod_q <= '0;
    end else begin
      vld_q  <= vld_d;
      rd_q   <= rd_d;
      f3_q   <= f3_d;
      prod_q <= prod_d;
    end
  end

  // funct3 000 and 1xx both select the low half.
  assign f3_last = f3_q[STAGES-1];
  assign lo_sel  = f3_last[2] || (f3_last[1:0] == 2'b00);

  assign bus.issue_ready_o = advance;
  assign bus.uses_o        = vld_q;
  assign bus.rd_addrs_o    = rd_q;
  assign bus.wb_we_o       = vld_q[STAGES-1];
  assign bus.wb_addr_o     = rd_q[STAGES-1];
  assign bus.wb_data_o     = lo_sel
                           ? prod_q[STAGES-1][XLEN-1:0]
                           : prod_q[STAGES-1][PW-1:XLEN];
endmodule

// File: doc/mult_manager.md
MULT_MANAGER -- requirements
Module: mult_manager

Interface
REQ-001 SHALL have parameter STAGES, default `MULT_PPL_STAGE, the number of multiplier pipeline stages (legal range 2..8).
REQ-002 SHALL have parameter XLEN, default 32, the operand and result width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 issue_valid_i  input  1  EX stage presents a multiply op.
REQ-006 issue_ready_o  output  1  manager can accept an op this cycle.
REQ-007 issue_funct3_i  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
REQ-008 issue_rs1_i  input  XLEN  operand A.
REQ-009 issue_rs2_i  input  XLEN  operand B.
REQ-010 issue_rd_i  input  5  destination register.
REQ-011 rd_addrs_o[STAGES-1:0]  output  5 each  per-stage in-flight destination, consumed by the stall controller.
REQ-012 uses_o  output  STAGES  per-stage valid bits.
REQ-013 wb_we_o  output  1  writeback request.
REQ-014 wb_addr_o  output  5  writeback register.
REQ-015 wb_data_o  output  XLEN  writeback data.
REQ-016 wb_ready_i  input  1  register-file write port granted to this unit.

Function
REQ-017 Acceptance SHALL occur when issue_valid_i && issue_ready_o && issue_rd_i != 0; an op with rd == 0 SHALL be silently dropped (never occupies a stage).
REQ-018 Stage k SHALL hold valid, rd, funct3 and a 2*XLEN product; stage 0 SHALL load on the edge of acceptance.
REQ-019 The product SHALL be computed from stage-0 operands on (XLEN+1)-bit extended operands: rs1 sign-extended for MULH/MULHSU, zero-extended otherwise; rs2 sign-extended for MULH only.
REQ-020 advance = !(uses_o[STAGES-1] && !wb_ready_i); when advance is 1 every stage k+1 SHALL load stage k, and stage 0 SHALL load the accepted op or become invalid.
REQ-021 When advance is 0 all stages SHALL hold unchanged.
REQ-022 issue_ready_o SHALL equal advance (combinational).
REQ-023 Latency: an op accepted at edge N SHALL present wb_we_o = 1 in the cycle after edge N+STAGES-1, i.e. STAGES cycles after issue, given wb_ready_i held high.
REQ-024 Throughput SHALL be one op per cycle with no bubbles while wb_ready_i = 1.
REQ-025 wb_we_o SHALL equal uses_o[STAGES-1]; wb_addr_o SHALL be that stage's rd; wb_data_o SHALL be product[XLEN-1:0] for MUL, else product[2*XLEN-1:XLEN].
REQ-026 Op retires at the edge where wb_we_o && wb_ready_i; a retiring op and a new issue in the same cycle SHALL both proceed.
REQ-027 Any stage with valid = 0 SHALL drive rd_addrs_o = 0 and product = 0; stall logic depends on this invariant.
REQ-028 Funct3 values 1xx SHALL be treated as MUL.
REQ-029 Ops SHALL retire strictly in issue order; no reordering or merging of same-rd ops.

Reset
REQ-030 While rst = 1 at an edge, all stage valid bits, rd fields, funct3 and products SHALL clear to 0; in-flight ops are discarded with no writeback.
REQ-031 Cycle after reset: uses_o = 0, all rd_addrs_o = 0, wb_we_o = 0, wb_addr_o = 0, wb_data_o = 0, issue_ready_o = 1.
REQ-032 An issue presented in the same cycle as rst = 1 SHALL be discarded.

Verification
REQ-033 STAGES=3: issue MUL rd=5, rs1=7, rs2=6 with wb_ready_i=1 -> uses_o one-hot walks bits 0,1,2; wb_we_o=1, wb_addr_o=5, wb_data_o=42 exactly 3 cycles after issue.
REQ-034 Signedness: rs1=0xFFFFFFFF, rs2=0x00000002 -> MULH 0xFFFFFFFF, MULHSU 0xFFFFFFFF, MULHU 0x00000001, MUL 0xFFFFFFFE.
REQ-035 Back-to-back issues rd=1,2,3 on consecutive cycles -> three consecutive writebacks in order 1,2,3 with no gap; uses_o reaches 3'b111.
REQ-036 Final stage valid and wb_ready_i=0 for 4 cycles -> issue_ready_o=0, all stage contents frozen; on wb_ready_i=1 retire resumes with no lost or duplicated op.
REQ-037 Issue with rd=0 -> uses_o stays 0, no writeback ever issued.
REQ-038 Two ops in flight, rst pulsed 1 cycle -> next cycle uses_o=0, rd_addrs_o all 0, no writeback of either op afterwards.
